// File: rtl/midi_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
//   Shared types and constants for the MIDI serial receiver.
//   - rx_state_e : receiver FSM states
//   - MIDI_BAUD / MIDI_CLK_HZ : default line rate and clock frequency
//   - MIDI_BYTE_W : payload width
//   - shift_in() : inserts one received bit into the shift register in the
//                  configured bit order
// ---------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int MIDI_BAUD   = 31250;
    localparam int MIDI_CLK_HZ = 100_000_000;
    localparam int MIDI_BYTE_W = 8;

    // lsb_first=1: shift right, new bit at MSB, so the first bit ends in bit 0.
    // lsb_first=0: shift left, new bit at LSB, so the first bit ends in the MSB.
    function automatic logic [MIDI_BYTE_W-1:0] shift_in(
        input logic [MIDI_BYTE_W-1:0] sh,
        input logic                   b,
        input logic                   lsb_first
    );
        if (lsb_first) return {b, sh[MIDI_BYTE_W-1:1]};
        else           return {sh[MIDI_BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// ---------------------------------------------------------------------------
// midi_uart_rx_if
//   Byte output bus of the MIDI receiver.
//   - o_data  : last correctly framed byte
//   - rdy_flg : one-cycle pulse when o_data is updated
//   master : receiver side (drives)   slave : consumer side (register wrapper)
// ---------------------------------------------------------------------------
interface midi_uart_rx_if;

    logic [midi_pkg::MIDI_BYTE_W-1:0] o_data;
    logic                             rdy_flg;

    modport master (output o_data, output rdy_flg);
    modport slave  (input  o_data, input  rdy_flg);

endinterface

// File: rtl/midi_uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for the asynchronous serial line. Both flops reset
//   to 1 so a reset never looks like a start-bit edge.
//   Ports: clk, rst (sync, active high), d_i (async in), q_o (synchronized)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) ff_q <= 2'b11;
        else     ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/midi_uart_rx.sv
// ---------------------------------------------------------------------------
// midi_uart_rx
//   8N1 serial receiver for MIDI. Samples every bit at its centre using a
//   baud counter driven from the start-bit falling edge, and publishes each
//   correctly framed byte with a one-cycle ready pulse.
//   Ports:
//     clk    : clock, rising edge
//     rst    : synchronous active-high reset
//     i_data : asynchronous serial line, idle high
//     out_o  : byte bus (o_data, rdy_flg) to the register wrapper
//   Parameters: CLK_FREQ_HZ, BAUD (CLK_FREQ_HZ/BAUD must be >= 4),
//               LSB_FIRST (1: first received bit lands in o_data[0])
// ---------------------------------------------------------------------------
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ_HZ = MIDI_CLK_HZ,
    parameter int BAUD        = MIDI_BAUD,
    parameter int LSB_FIRST   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_data,
    midi_uart_rx_if.master out_o
);

    localparam int BIT_CYC  = CLK_FREQ_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic             LSB_F     = (LSB_FIRST != 0);

    logic rx_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (i_data),
        .q_o (rx_s)
    );

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [2:0]             idx_q,   idx_d;
    logic [MIDI_BYTE_W-1:0] sh_q,    sh_d;
    logic [MIDI_BYTE_W-1:0] data_q,  data_d;
    logic                   rdy_q,   rdy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rdy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            // The detect cycle already covers one cycle of the start bit,
            // so the centre is reached when the counter hits HALF_CYC-1.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;   // glitch shorter than half a bit
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = shift_in(sh_q, rx_s, LSB_F);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Return to IDLE at the stop-bit centre so a start bit that
            // follows with no idle gap is still caught on its edge.
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = sh_q;
                        rdy_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign out_o.o_data  = data_q;
    assign out_o.rdy_flg = rdy_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_midi_uart_rx
//   Directed bench for midi_uart_rx at CLK_FREQ_HZ=16, BAUD=1 (16 cycles per
//   bit). Two receivers share the line: u_a (LSB first) and u_b (MSB first).
// ---------------------------------------------------------------------------
module tb_midi_uart_rx;
    import midi_pkg::*;

    localparam int BC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_data = 1'b1;

    midi_uart_rx_if if_a ();
    midi_uart_rx_if if_b ();

    midi_uart_rx #(.CLK_FREQ_HZ(16), .BAUD(1), .LSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .i_data(i_data), .out_o(if_a.master));
    midi_uart_rx #(.CLK_FREQ_HZ(16), .BAUD(1), .LSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .i_data(i_data), .out_o(if_b.master));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors: record data and cycle of every rdy pulse, and count
    // any cycle where rdy stays high for a second cycle.
    int         pa_cnt = 0, pb_cnt = 0, wide = 0;
    logic [7:0] pa_data[$], pb_data[$];
    int         pa_cyc[$];
    logic       ra_prev = 1'b0, rb_prev = 1'b0;

    always @(negedge clk) begin
        if (if_a.rdy_flg === 1'b1) begin
            pa_cnt++;
            pa_data.push_back(if_a.o_data);
            pa_cyc.push_back(cyc);
            if (ra_prev) wide++;
        end
        if (if_b.rdy_flg === 1'b1) begin
            pb_cnt++;
            pb_data.push_back(if_b.o_data);
            if (rb_prev) wide++;
        end
        ra_prev = (if_a.rdy_flg === 1'b1);
        rb_prev = (if_b.rdy_flg === 1'b1);
    end

    task automatic line(input logic v, input int n);
        i_data = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        line(1'b0, BC);
        for (int i = 0; i < 8; i++) line(b[i], BC);
        if (stop_v) line(1'b1, BC);
        else begin
            line(1'b0, 12);     // low across the stop centre, then idle
            line(1'b1, 4);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_data = i[0];
            @(negedge clk);
            n_chk++;
            if (if_a.o_data !== 8'h00 || if_a.rdy_flg !== 1'b0 ||
                if_b.o_data !== 8'h00 || if_b.rdy_flg !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: a=%h/%b b=%h/%b expected 00/0",
                         if_a.o_data, if_a.rdy_flg, if_b.o_data, if_b.rdy_flg);
            end
        end
        i_data = 1'b1;
        rst    = 1'b0;
        repeat (40) @(negedge clk);
        n_chk++;
        if (if_a.o_data !== 8'h00 || if_b.o_data !== 8'h00 || pa_cnt != 0 || pb_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_release: a=%h b=%h pulses=%0d/%0d expected 00 00 0/0",
                     if_a.o_data, if_b.o_data, pa_cnt, pb_cnt);
        end
        n_chk++;
        if (u_a.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected IDLE", u_a.state_q);
        end
    endtask

    task automatic test_bit_order();
        int a0, b0, t0;
        a0 = pa_cnt; b0 = pb_cnt; t0 = cyc;
        send_frame(8'h90, 1'b1);
        line(1'b1, 20);
        n_chk++;
        if (pa_cnt != a0 + 1 || pb_cnt != b0 + 1) begin
            n_fail++;
            $display("FAIL order_pulses: a=%0d b=%0d expected 1 1", pa_cnt - a0, pb_cnt - b0);
        end else begin
            n_chk++;
            if (pa_data[a0] !== 8'h90) begin
                n_fail++;
                $display("FAIL lsb_first_data: got %h expected 90", pa_data[a0]);
            end
            n_chk++;
            if (pb_data[b0] !== 8'h09) begin
                n_fail++;
                $display("FAIL msb_first_data: got %h expected 09", pb_data[b0]);
            end
            n_chk++;
            if (pa_cyc[a0] - t0 < 154 || pa_cyc[a0] - t0 > 156) begin
                n_fail++;
                $display("FAIL latency: got %0d expected 155 +-1", pa_cyc[a0] - t0);
            end
        end
        n_chk++;
        if (if_a.o_data !== 8'h90 || if_b.o_data !== 8'h09) begin
            n_fail++;
            $display("FAIL order_hold: a=%h b=%h expected 90 09", if_a.o_data, if_b.o_data);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = pa_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7F, 1'b1);
        line(1'b1, 20);
        n_chk++;
        if (pa_cnt != a0 + 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 2", pa_cnt - a0);
        end else begin
            n_chk++;
            if (pa_data[a0] !== 8'h3C || pa_data[a0+1] !== 8'h7F) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h expected 3c 7f", pa_data[a0], pa_data[a0+1]);
            end
            n_chk++;
            if (pa_cyc[a0+1] - pa_cyc[a0] != 10 * BC) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d expected 160", pa_cyc[a0+1] - pa_cyc[a0]);
            end
        end
        n_chk++;
        if (if_a.o_data !== 8'h7F) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h expected 7f", if_a.o_data);
        end
    endtask

    task automatic test_glitch();
        int a0;
        a0 = pa_cnt;
        line(1'b0, 4);
        line(1'b1, 30);
        n_chk++;
        if (pa_cnt != a0 || u_a.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL glitch_reject: pulses=%0d state=%0d expected 0 IDLE",
                     pa_cnt - a0, u_a.state_q);
        end
        send_frame(8'hA5, 1'b1);
        line(1'b1, 20);
        n_chk++;
        if (pa_cnt != a0 + 1 || if_a.o_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL glitch_recover: pulses=%0d data=%h expected 1 a5",
                     pa_cnt - a0, if_a.o_data);
        end
    endtask

    task automatic test_framing_and_reset();
        int a0, b0;
        a0 = pa_cnt;
        send_frame(8'h55, 1'b0);
        line(1'b1, 40);
        n_chk++;
        if (pa_cnt != a0 || if_a.o_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL framing_error: pulses=%0d data=%h expected 0 a5",
                     pa_cnt - a0, if_a.o_data);
        end
        // Re-establish 7F as the held value, then test framing error again.
        send_frame(8'h7F, 1'b1);
        line(1'b1, 20);
        a0 = pa_cnt;
        send_frame(8'h55, 1'b0);
        line(1'b1, 40);
        n_chk++;
        if (pa_cnt != a0 || if_a.o_data !== 8'h7F) begin
            n_fail++;
            $display("FAIL framing_hold: pulses=%0d data=%h expected 0 7f",
                     pa_cnt - a0, if_a.o_data);
        end
        a0 = pa_cnt; b0 = pb_cnt;
        line(1'b0, BC);                       // start bit
        line(1'b1, BC); line(1'b0, BC); line(1'b1, BC / 2);
        n_chk++;
        if (u_a.state_q !== DATA) begin
            n_fail++;
            $display("FAIL mid_frame_state: got %0d expected DATA", u_a.state_q);
        end
        i_data = 1'b1;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line(1'b1, 200);
        n_chk++;
        if (pa_cnt != a0 || pb_cnt != b0 || if_a.o_data !== 8'h00 || if_b.o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_abort: pulses=%0d/%0d data=%h/%h expected 0/0 00/00",
                     pa_cnt - a0, pb_cnt - b0, if_a.o_data, if_b.o_data);
        end
        n_chk++;
        if (u_a.state_q !== IDLE || if_a.rdy_flg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_state: state=%0d rdy=%b expected IDLE 0",
                     u_a.state_q, if_a.rdy_flg);
        end
    endtask

    task automatic test_pulse_width();
        n_chk++;
        if (wide != 0) begin
            n_fail++;
            $display("FAIL pulse_width: %0d extended pulses, expected 0", wide);
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_glitch();
        test_framing_and_reset();
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
